// File: rtl/fix_seq_checker.sv
// FIX MsgSeqNum checker: classifies each parsed message against a per-host expected-sequence
// table and emits a one-cycle result pulse for session_manager.
module fix_seq_checker #(
  parameter int NUM_HOSTS = 1024,
  parameter int HOST_W    = 10,
  parameter int SEQ_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_valid_i,
  output logic              msg_ready_o,
  input  logic [HOST_W-1:0] host_i,
  input  logic [2:0]        type_i,
  input  logic [SEQ_W-1:0]  seqnum_i,
  input  logic              possdup_i,
  input  logic              resetflag_i,
  input  logic              set_i,
  input  logic [HOST_W-1:0] set_host_i,
  input  logic [SEQ_W-1:0]  set_val_i,
  input  logic              clear_i,
  input  logic [HOST_W-1:0] clear_host_i,
  output logic              new_message_o,
  output logic [2:0]        validity_o,
  output logic [2:0]        type_o,
  output logic [HOST_W-1:0] host_o,
  output logic [SEQ_W-1:0]  seqnum_o,
  output logic [SEQ_W-1:0]  expected_o,
  output logic [0:0]        state_o
);

  localparam int IDX_W = (NUM_HOSTS > 1) ? $clog2(NUM_HOSTS) : 1;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [2:0] V_OK       = 3'd0;
  localparam logic [2:0] V_GAP      = 3'd1;
  localparam logic [2:0] V_DUP      = 3'd2;
  localparam logic [2:0] V_LOW      = 3'd3;
  localparam logic [2:0] V_BAD_HOST = 3'd4;
  localparam logic [2:0] V_BAD_SEQ  = 3'd5;

  localparam logic [2:0] TYPE_LOGON = 3'd1;

  logic [0:0]       state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [SEQ_W-1:0] table_q [NUM_HOSTS];

  logic             accept;
  logic             bad_host;
  logic             set_ok;
  logic             clear_ok;
  logic [IDX_W-1:0] msg_idx;
  logic [IDX_W-1:0] set_idx;
  logic [IDX_W-1:0] clear_idx;
  logic [SEQ_W-1:0] exp_val;
  logic [SEQ_W-1:0] set_wr_val;
  logic [2:0]       verdict;
  logic             msg_wr;
  logic [SEQ_W-1:0] msg_wr_val;

  // Sequence numbers never legitimately become 0, so the increment skips it on wrap.
  function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] v);
    return (&v) ? SEQ_W'(1) : v + SEQ_W'(1);
  endfunction

  assign msg_ready_o = (state_q == ST_RUN);
  assign state_o     = state_q;
  assign accept      = msg_valid_i & msg_ready_o;

  assign bad_host  = 32'(host_i) >= 32'(NUM_HOSTS);
  assign set_ok    = set_i & (32'(set_host_i) < 32'(NUM_HOSTS));
  assign clear_ok  = clear_i & (32'(clear_host_i) < 32'(NUM_HOSTS));
  assign msg_idx   = host_i[IDX_W-1:0];
  assign set_idx   = set_host_i[IDX_W-1:0];
  assign clear_idx = clear_host_i[IDX_W-1:0];

  assign exp_val    = bad_host ? '0 : table_q[msg_idx];
  assign set_wr_val = (set_val_i == '0) ? SEQ_W'(1) : set_val_i;

  always_comb begin
    verdict    = V_OK;
    msg_wr     = 1'b0;
    msg_wr_val = '0;
    if (bad_host) begin
      verdict = V_BAD_HOST;
    end else if (seqnum_i == '0) begin
      verdict = V_BAD_SEQ;
    end else if (type_i == TYPE_LOGON && resetflag_i) begin
      verdict    = V_OK;
      msg_wr     = 1'b1;
      msg_wr_val = seq_inc(seqnum_i);
    end else if (seqnum_i == exp_val) begin
      verdict    = V_OK;
      msg_wr     = 1'b1;
      msg_wr_val = seq_inc(exp_val);
    end else if (seqnum_i > exp_val) begin
      verdict = V_GAP;
    end else if (possdup_i) begin
      verdict = V_DUP;
    end else begin
      verdict = V_LOW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_INIT;
      ptr_q   <= '0;
    end else if (state_q == ST_INIT) begin
      ptr_q <= ptr_q + IDX_W'(1);
      if (ptr_q == IDX_W'(NUM_HOSTS - 1)) state_q <= ST_RUN;
    end
  end

  // Later assignments win, giving clear > set > message update for a shared host.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      table_q[ptr_q] <= SEQ_W'(1);
    end else begin
      if (accept && msg_wr) table_q[msg_idx] <= msg_wr_val;
      if (set_ok)           table_q[set_idx] <= set_wr_val;
      if (clear_ok)         table_q[clear_idx] <= SEQ_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      new_message_o <= 1'b0;
      validity_o    <= '0;
      type_o        <= '0;
      host_o        <= '0;
      seqnum_o      <= '0;
      expected_o    <= '0;
    end else begin
      new_message_o <= accept;
      if (accept) begin
        validity_o <= verdict;
        type_o     <= type_i;
        host_o     <= host_i;
        seqnum_o   <= seqnum_i;
        expected_o <= exp_val;
      end
    end
  end

endmodule

// File: tb/tb_fix_seq_checker.sv
// Directed bench for fix_seq_checker with an 8-entry table: init sweep, classification,
// same-cycle write priority, wrap arithmetic and reset during the sweep.
module tb_fix_seq_checker;

  localparam int NH = 8;
  localparam int HW = 10;
  localparam int SW = 32;

  localparam logic [2:0] V_OK       = 3'd0;
  localparam logic [2:0] V_GAP      = 3'd1;
  localparam logic [2:0] V_DUP      = 3'd2;
  localparam logic [2:0] V_LOW      = 3'd3;
  localparam logic [2:0] V_BAD_HOST = 3'd4;
  localparam logic [2:0] V_BAD_SEQ  = 3'd5;

  logic          clk = 1'b0;
  logic          rst;
  logic          msg_valid_i;
  logic          msg_ready_o;
  logic [HW-1:0] host_i;
  logic [2:0]    type_i;
  logic [SW-1:0] seqnum_i;
  logic          possdup_i;
  logic          resetflag_i;
  logic          set_i;
  logic [HW-1:0] set_host_i;
  logic [SW-1:0] set_val_i;
  logic          clear_i;
  logic [HW-1:0] clear_host_i;
  logic          new_message_o;
  logic [2:0]    validity_o;
  logic [2:0]    type_o;
  logic [HW-1:0] host_o;
  logic [SW-1:0] seqnum_o;
  logic [SW-1:0] expected_o;
  logic [0:0]    state_o;

  int vectors     = 0;
  int miscompares = 0;

  fix_seq_checker #(.NUM_HOSTS(NH), .HOST_W(HW), .SEQ_W(SW)) dut (
    .clk(clk), .rst(rst),
    .msg_valid_i(msg_valid_i), .msg_ready_o(msg_ready_o),
    .host_i(host_i), .type_i(type_i), .seqnum_i(seqnum_i),
    .possdup_i(possdup_i), .resetflag_i(resetflag_i),
    .set_i(set_i), .set_host_i(set_host_i), .set_val_i(set_val_i),
    .clear_i(clear_i), .clear_host_i(clear_host_i),
    .new_message_o(new_message_o), .validity_o(validity_o), .type_o(type_o),
    .host_o(host_o), .seqnum_o(seqnum_o), .expected_o(expected_o),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_msg(input logic [HW-1:0] h, input logic [2:0] t, input logic [SW-1:0] s,
                           input logic pd, input logic rf);
    msg_valid_i = 1'b1;
    host_i      = h;
    type_i      = t;
    seqnum_i    = s;
    possdup_i   = pd;
    resetflag_i = rf;
  endtask

  task automatic idle_msg();
    msg_valid_i = 1'b0;
    host_i      = '0;
    type_i      = '0;
    seqnum_i    = '0;
    possdup_i   = 1'b0;
    resetflag_i = 1'b0;
  endtask

  task automatic do_set(input logic [HW-1:0] h, input logic [SW-1:0] v);
    set_i      = 1'b1;
    set_host_i = h;
    set_val_i  = v;
    step();
    set_i = 1'b0;
  endtask

  task automatic chk_pulse(input string tag, input logic [2:0] v, input logic [SW-1:0] e);
    chk({tag, "_pulse"}, new_message_o, 1);
    chk({tag, "_validity"}, validity_o, v);
    chk({tag, "_expected"}, expected_o, e);
  endtask

  initial begin
    rst = 1'b1;
    idle_msg();
    set_i = 1'b0; set_host_i = '0; set_val_i = '0;
    clear_i = 1'b0; clear_host_i = '0;

    #12;
    chk("rst_ready", msg_ready_o, 0);
    chk("rst_pulse", new_message_o, 0);
    chk("rst_expected", expected_o, 0);
    chk("rst_state", state_o, 0);

    @(negedge clk) rst = 1'b0;
    for (int i = 1; i <= NH; i++) begin
      step();
      chk($sformatf("init_ready_%0d", i), msg_ready_o, (i == NH) ? 1 : 0);
    end

    // Host 3 in order from the initial expected value of 1, back to back.
    drive_msg(3, 0, 1, 0, 0); step();
    chk_pulse("h3_s1", V_OK, 1);
    chk("h3_s1_host", host_o, 3);
    chk("h3_s1_seq", seqnum_o, 1);
    drive_msg(3, 0, 2, 0, 0); step();
    chk_pulse("h3_s2", V_OK, 2);
    drive_msg(3, 0, 3, 0, 0); step();
    chk_pulse("h3_s3", V_OK, 3);
    idle_msg(); step();
    chk("idle_no_pulse", new_message_o, 0);

    // Host 3 now expects 4.
    drive_msg(3, 0, 7, 0, 0); step();
    chk_pulse("h3_gap", V_GAP, 4);
    drive_msg(3, 0, 2, 1, 0); step();
    chk_pulse("h3_dup", V_DUP, 4);
    drive_msg(3, 0, 2, 0, 0); step();
    chk_pulse("h3_low", V_LOW, 4);
    drive_msg(3, 0, 1, 0, 1); step();
    chk_pulse("h3_rf_non_logon", V_LOW, 4);
    idle_msg();

    do_set(5, 9);
    drive_msg(5, 1, 1, 0, 1); step();
    chk_pulse("h5_logon_reset", V_OK, 9);
    chk("h5_logon_type", type_o, 1);
    drive_msg(5, 0, 2, 0, 0); step();
    chk_pulse("h5_after_logon", V_OK, 2);
    drive_msg(9, 0, 5, 0, 0); step();
    chk_pulse("bad_host", V_BAD_HOST, 0);
    chk("bad_host_host", host_o, 9);
    drive_msg(5, 0, 0, 0, 0); step();
    chk_pulse("bad_seq", V_BAD_SEQ, 3);
    idle_msg();

    // Message, set and clear all aimed at host 2 in one cycle: clear wins.
    do_set(2, 6);
    drive_msg(2, 0, 6, 0, 0);
    set_i = 1'b1; set_host_i = 2; set_val_i = 20;
    clear_i = 1'b1; clear_host_i = 2;
    step();
    set_i = 1'b0; clear_i = 1'b0;
    chk_pulse("h2_same_cycle", V_OK, 6);
    drive_msg(2, 0, 5, 0, 0); step();
    chk_pulse("h2_after_clear", V_GAP, 1);
    idle_msg();

    do_set(4, 32'hFFFF_FFFF);
    drive_msg(4, 0, 32'hFFFF_FFFF, 0, 0); step();
    chk_pulse("h4_max", V_OK, 32'hFFFF_FFFF);
    drive_msg(4, 0, 1, 0, 0); step();
    chk_pulse("h4_wrapped", V_OK, 1);
    idle_msg();
    do_set(6, 0);
    drive_msg(6, 0, 1, 0, 0); step();
    chk_pulse("h6_set_zero", V_OK, 1);

    // Writes to three different hosts in one cycle.
    drive_msg(7, 0, 1, 0, 0);
    set_i = 1'b1; set_host_i = 0; set_val_i = 50;
    clear_i = 1'b1; clear_host_i = 3;
    step();
    set_i = 1'b0; clear_i = 1'b0;
    chk_pulse("multi_h7", V_OK, 1);
    drive_msg(0, 0, 50, 0, 0); step();
    chk_pulse("multi_h0", V_OK, 50);
    drive_msg(7, 0, 2, 0, 0); step();
    chk_pulse("multi_h7_next", V_OK, 2);
    drive_msg(3, 0, 1, 0, 0); step();
    chk_pulse("multi_h3_cleared", V_OK, 1);

    // Reset with a message in flight, then again midway through the sweep.
    drive_msg(3, 0, 2, 0, 0);
    #2 rst = 1'b1;
    step();
    chk("inflight_pulse", new_message_o, 0);
    chk("rst2_validity", validity_o, 0);
    chk("rst2_expected", expected_o, 0);
    chk("rst2_host", host_o, 0);
    chk("rst2_seq", seqnum_o, 0);
    chk("rst2_ready", msg_ready_o, 0);
    idle_msg();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_sweep_ready", msg_ready_o, 0);
    @(negedge clk) rst = 1'b1;
    #1;
    chk("mid_sweep_rst_state", state_o, 0);
    @(negedge clk) rst = 1'b0;
    for (int i = 1; i <= NH; i++) begin
      step();
      chk($sformatf("reinit_ready_%0d", i), msg_ready_o, (i == NH) ? 1 : 0);
    end
    drive_msg(3, 0, 1, 0, 0); step();
    chk_pulse("h3_reinit", V_OK, 1);
    idle_msg(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
